// File: rtl/ptp_cfg_sequencer.sv
// ptp_cfg_sequencer: runs the ptpv2 core bring-up write sequence on start and passes host accesses through otherwise.
// Optional ack timeout enabled by defining PTP_CFG_SEQ_TIMEOUT_EN.
`ifndef TSU_BLK_ADDR
`define TSU_BLK_ADDR 4'h1
`endif
`ifndef TSU_CFG_ADDR
`define TSU_CFG_ADDR 4'h0
`endif
`ifndef RTC_BLK_ADDR
`define RTC_BLK_ADDR 4'h2
`endif
`ifndef TICK_INC_ADDR
`define TICK_INC_ADDR 4'h0
`endif
`ifndef NS_OFST_ADDR
`define NS_OFST_ADDR 4'h1
`endif
`ifndef SC_OFST0_ADDR
`define SC_OFST0_ADDR 4'h2
`endif
`ifndef SC_OFST1_ADDR
`define SC_OFST1_ADDR 4'h3
`endif
`ifndef RTC_CTL_ADDR
`define RTC_CTL_ADDR 4'h4
`endif
module ptp_cfg_sequencer #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] TSU_CFG_A = {`TSU_BLK_ADDR, `TSU_CFG_ADDR},
  parameter logic [ADDR_W-1:0] TICK_A = {`RTC_BLK_ADDR, `TICK_INC_ADDR},
  parameter logic [ADDR_W-1:0] NS_A = {`RTC_BLK_ADDR, `NS_OFST_ADDR},
  parameter logic [ADDR_W-1:0] SC0_A = {`RTC_BLK_ADDR, `SC_OFST0_ADDR},
  parameter logic [ADDR_W-1:0] SC1_A = {`RTC_BLK_ADDR, `SC_OFST1_ADDR},
  parameter logic [ADDR_W-1:0] CTL_A = {`RTC_BLK_ADDR, `RTC_CTL_ADDR},
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              init_rtc_i,
  input  logic [2:0]        clk_ctl_i,
  input  logic              bypass_i,
  input  logic [31:0]       tick_inc_i,
  input  logic [31:0]       ns_ofst_i,
  input  logic [47:0]       sc_ofst_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              host_req_i,
  input  logic              host_wr_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [31:0]       host_wdata_i,
  output logic              host_ack_o,
  output logic [31:0]       host_rdata_o,
  output logic              reg_wr_o,
  output logic              reg_rd_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  input  logic              reg_ack_i,
  input  logic [31:0]       reg_rdata_i
);
  typedef enum logic [2:0] {IDLE, HOST, SEQ_ISSUE, SEQ_WAIT, GAP, DONE} state_t;
  state_t state, state_n;
  logic acc, go, pend, seq_stb, stb, tmo, rtc_s, bypass_s;
  logic [2:0] clk_ctl_s, idx, last;
  logic [31:0] tick_s, ns_s;
  logic [47:0] sc_s;
  assign busy_o = state inside {SEQ_ISSUE, SEQ_WAIT, GAP, DONE};
  assign acc = start_i && !busy_o;
  assign go = start_i || pend;
  assign seq_stb = state inside {SEQ_ISSUE, SEQ_WAIT};
  assign stb = seq_stb || state == HOST;
  assign last = rtc_s ? 3'd5 : 3'd1;
`ifdef PTP_CFG_SEQ_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = stb && !reg_ack_i && cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err_o <= 1'b0;
    end else begin
      cnt <= stb ? cnt + 8'd1 : 8'd0;
      err_o <= acc ? 1'b0 : tmo ? 1'b1 : err_o;
    end
`else
  assign tmo = 1'b0;
  assign err_o = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // host_ack_o marks the turnaround cycle: nothing new is accepted while it is high
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = host_ack_o ? IDLE : go ? SEQ_ISSUE : host_req_i ? HOST : IDLE;
      HOST: state_n = (reg_ack_i || tmo) ? IDLE : HOST;
      SEQ_ISSUE, SEQ_WAIT: state_n = tmo ? IDLE : !reg_ack_i ? SEQ_WAIT : idx == last ? DONE : GAP;
      GAP: state_n = SEQ_ISSUE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    reg_wr_o = seq_stb || (state == HOST && host_wr_i);
    reg_rd_o = state == HOST && !host_wr_i;
    reg_addr_o = state == HOST ? host_addr_i : !seq_stb ? '0 :
                 idx == 3'd0 ? TSU_CFG_A : idx == 3'd1 ? TICK_A : idx == 3'd2 ? NS_A :
                 idx == 3'd3 ? SC0_A : idx == 3'd4 ? SC1_A : CTL_A;
    reg_wdata_o = state == HOST ? host_wdata_i : !seq_stb ? '0 :
                  idx == 3'd0 ? {27'b0, bypass_s, 1'b0, clk_ctl_s} : idx == 3'd1 ? tick_s :
                  idx == 3'd2 ? ns_s : idx == 3'd3 ? {16'b0, sc_s[47:32]} :
                  idx == 3'd4 ? sc_s[31:0] : 32'h1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= 1'b0;
      rtc_s <= 1'b0;
      bypass_s <= 1'b0;
      clk_ctl_s <= '0;
      tick_s <= '0;
      ns_s <= '0;
      sc_s <= '0;
      idx <= '0;
      done_o <= 1'b0;
      host_ack_o <= 1'b0;
      host_rdata_o <= '0;
    end else begin
      pend <= (state == IDLE && state_n == SEQ_ISSUE) ? 1'b0 : pend || acc;
      if (acc) begin
        rtc_s <= init_rtc_i;
        bypass_s <= bypass_i;
        clk_ctl_s <= clk_ctl_i;
        tick_s <= tick_inc_i;
        ns_s <= ns_ofst_i;
        sc_s <= sc_ofst_i;
      end
      idx <= (seq_stb && reg_ack_i) ? idx + 3'd1 : state == IDLE ? 3'd0 : idx;
      done_o <= acc ? 1'b0 : state == DONE ? 1'b1 : done_o;
      host_ack_o <= state == HOST && (reg_ack_i || tmo);
      host_rdata_o <= (state == HOST && reg_ack_i) ? reg_rdata_i :
                      (state == HOST && tmo) ? 32'hDEAD_BEEF : host_rdata_o;
    end
endmodule

// File: tb/tb_ptp_cfg_sequencer.sv
// tb_ptp_cfg_sequencer: directed bench for ptp_cfg_sequencer with a zero-wait core responder.
module tb_ptp_cfg_sequencer;
  logic clk = 0, rst = 1;
  logic start_i = 0, init_rtc_i = 0, bypass_i = 0;
  logic [2:0] clk_ctl_i = 0;
  logic [31:0] tick_inc_i = 0, ns_ofst_i = 0;
  logic [47:0] sc_ofst_i = 0;
  logic busy_o, done_o, err_o;
  logic host_req_i = 0, host_wr_i = 0;
  logic [7:0] host_addr_i = 0;
  logic [31:0] host_wdata_i = 0;
  logic host_ack_o;
  logic [31:0] host_rdata_o;
  logic reg_wr_o, reg_rd_o, reg_ack_i;
  logic [7:0] reg_addr_o;
  logic [31:0] reg_wdata_o, reg_rdata_i;
  logic ack_en = 1;
  int cyc = 0, s0, checks = 0, errors = 0;
  logic [7:0] la[$];
  logic [31:0] ld[$];
  int lc[$];

  ptp_cfg_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .init_rtc_i(init_rtc_i), .clk_ctl_i(clk_ctl_i),
    .bypass_i(bypass_i), .tick_inc_i(tick_inc_i), .ns_ofst_i(ns_ofst_i), .sc_ofst_i(sc_ofst_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .host_req_i(host_req_i), .host_wr_i(host_wr_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o),
    .host_rdata_o(host_rdata_o), .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst)
    if (rst) begin
      reg_ack_i <= 0;
      reg_rdata_i <= 0;
    end else begin
      if (reg_ack_i && reg_wr_o) begin
        la.push_back(reg_addr_o);
        ld.push_back(reg_wdata_o);
        lc.push_back(cyc);
      end
      reg_ack_i <= (reg_wr_o || reg_rd_o) && !reg_ack_i && ack_en;
      reg_rdata_i <= {24'hC0DE00, reg_addr_o};
    end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    la.delete(); ld.delete(); lc.delete();
  endtask

  task automatic pulse_start();
    start_i = 1; s0 = cyc;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy_o, done_o, err_o, host_ack_o, reg_wr_o, reg_rd_o} !== 6'b0 || reg_addr_o !== 8'h0 ||
        reg_wdata_o !== 32'h0 || host_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got flags=%b addr=%h wdata=%h rdata=%h exp all zero",
               {busy_o, done_o, err_o, host_ack_o, reg_wr_o, reg_rd_o}, reg_addr_o, reg_wdata_o, host_rdata_o);
    end
    @(negedge clk);
    rst = 0;
    wait_n(2);
  endtask

  task automatic test_full_seq();
    logic [7:0] ea[6];
    logic [31:0] ed[6];
    ea = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    ed = '{32'h1, 32'h1999_999a, 32'h1234_5678, 32'h0000_3ccc, 32'hcccc_cccc, 32'h1};
    clear_log();
    init_rtc_i = 1; clk_ctl_i = 3'b001; bypass_i = 0;
    tick_inc_i = 32'h1999_999a; ns_ofst_i = 32'h1234_5678; sc_ofst_i = 48'h3ccc_cccc_cccc;
    pulse_start();
    checks++;
    if (busy_o !== 1 || reg_wr_o !== 1 || reg_addr_o !== 8'h10) begin
      errors++;
      $display("FAIL full_first_strobe got busy=%b wr=%b addr=%h exp 1 1 10", busy_o, reg_wr_o, reg_addr_o);
    end
    wait_n(17);
    checks++;
    if (busy_o !== 1 || done_o !== 0) begin
      errors++; $display("FAIL full_cycle18 got busy=%b done=%b exp 1 0", busy_o, done_o);
    end
    wait_n(1);
    checks++;
    if (busy_o !== 0 || done_o !== 1) begin
      errors++; $display("FAIL full_cycle19 got busy=%b done=%b exp 0 1", busy_o, done_o);
    end
    checks++;
    if (la.size() != 6) begin
      errors++; $display("FAIL full_write_count got %0d exp 6", la.size());
    end else
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (la[i] !== ea[i] || ld[i] !== ed[i] || lc[i] != s0 + 2 + 3 * i) begin
          errors++;
          $display("FAIL full_write%0d got addr=%h data=%h ackcyc=%0d exp addr=%h data=%h ackcyc=%0d",
                   i, la[i], ld[i], lc[i] - s0, ea[i], ed[i], 2 + 3 * i);
        end
      end
  endtask

  task automatic test_short_seq();
    clear_log();
    init_rtc_i = 0; bypass_i = 1; clk_ctl_i = 3'b101; tick_inc_i = 32'h0000_abcd;
    pulse_start();
    tick_inc_i = 32'hffff_0000; bypass_i = 0; clk_ctl_i = 3'b000; init_rtc_i = 1;
    wait_n(5);
    checks++;
    if (done_o !== 0) begin errors++; $display("FAIL short_done_early got %b exp 0", done_o); end
    wait_n(1);
    checks++;
    if (done_o !== 1 || busy_o !== 0) begin
      errors++; $display("FAIL short_done got done=%b busy=%b exp 1 0", done_o, busy_o);
    end
    checks++;
    if (la.size() != 2) begin
      errors++; $display("FAIL short_write_count got %0d exp 2", la.size());
    end else if (la[0] !== 8'h10 || ld[0] !== 32'h15 || la[1] !== 8'h20 || ld[1] !== 32'h0000_abcd) begin
      errors++;
      $display("FAIL short_writes got %h:%h %h:%h exp 10:00000015 20:0000abcd", la[0], ld[0], la[1], ld[1]);
    end
    init_rtc_i = 0;
  endtask

  task automatic test_host_then_start();
    clear_log();
    init_rtc_i = 0; bypass_i = 0; clk_ctl_i = 3'b010; tick_inc_i = 32'h5;
    host_req_i = 1; host_wr_i = 0; host_addr_i = 8'h33;
    wait_n(1);
    checks++;
    if (reg_rd_o !== 1 || reg_wr_o !== 0 || reg_addr_o !== 8'h33 || busy_o !== 0) begin
      errors++;
      $display("FAIL host_rd_strobe got rd=%b wr=%b addr=%h busy=%b exp 1 0 33 0", reg_rd_o, reg_wr_o, reg_addr_o, busy_o);
    end
    start_i = 1;
    wait_n(1);
    start_i = 0;
    checks++;
    if (reg_rd_o !== 1 || host_ack_o !== 0) begin
      errors++; $display("FAIL host_hold got rd=%b ack=%b exp 1 0", reg_rd_o, host_ack_o);
    end
    wait_n(1);
    checks++;
    if (host_ack_o !== 1 || host_rdata_o !== 32'hC0DE_0033 || reg_rd_o !== 0) begin
      errors++;
      $display("FAIL host_ack got ack=%b rdata=%h rd=%b exp 1 c0de0033 0", host_ack_o, host_rdata_o, reg_rd_o);
    end
    host_req_i = 0;
    wait_n(1);
    checks++;
    if (reg_wr_o !== 0 || reg_rd_o !== 0 || host_ack_o !== 0) begin
      errors++; $display("FAIL host_turnaround got wr=%b rd=%b ack=%b exp 0 0 0", reg_wr_o, reg_rd_o, host_ack_o);
    end
    wait_n(1);
    checks++;
    if (reg_wr_o !== 1 || busy_o !== 1 || reg_addr_o !== 8'h10 || reg_wdata_o !== 32'h2) begin
      errors++;
      $display("FAIL latched_start got wr=%b busy=%b addr=%h data=%h exp 1 1 10 00000002", reg_wr_o, busy_o, reg_addr_o, reg_wdata_o);
    end
    wait_n(6);
    checks++;
    if (done_o !== 1 || la.size() != 2) begin
      errors++; $display("FAIL latched_done got done=%b writes=%0d exp 1 2", done_o, la.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    init_rtc_i = 0;
    pulse_start();
    host_req_i = 1; host_wr_i = 1; host_addr_i = 8'h44; host_wdata_i = 32'h77;
    wait_n(2);
    start_i = 1;
    checks++;
    if (host_ack_o !== 0 || reg_wr_o !== 0 || busy_o !== 1) begin
      errors++; $display("FAIL stall_gap got ack=%b wr=%b busy=%b exp 0 0 1", host_ack_o, reg_wr_o, busy_o);
    end
    wait_n(1);
    start_i = 0;
    checks++;
    if (reg_addr_o !== 8'h20 || reg_wdata_o !== 32'h5) begin
      errors++; $display("FAIL stall_seq_item got addr=%h data=%h exp 20 00000005", reg_addr_o, reg_wdata_o);
    end
    wait_n(3);
    checks++;
    if (reg_wr_o !== 0 || busy_o !== 0 || done_o !== 1 || host_ack_o !== 0) begin
      errors++;
      $display("FAIL stall_after_done got wr=%b busy=%b done=%b ack=%b exp 0 0 1 0", reg_wr_o, busy_o, done_o, host_ack_o);
    end
    wait_n(1);
    checks++;
    if (reg_wr_o !== 1 || reg_addr_o !== 8'h44 || reg_wdata_o !== 32'h77) begin
      errors++;
      $display("FAIL stall_host_issue got wr=%b addr=%h data=%h exp 1 44 00000077", reg_wr_o, reg_addr_o, reg_wdata_o);
    end
    wait_n(2);
    checks++;
    if (host_ack_o !== 1) begin errors++; $display("FAIL stall_host_ack got %b exp 1", host_ack_o); end
    host_req_i = 0;
    wait_n(4);
    checks++;
    if (la.size() != 3 || busy_o !== 0 || host_ack_o !== 0 || reg_wr_o !== 0) begin
      errors++;
      $display("FAIL no_restart got writes=%0d busy=%b ack=%b wr=%b exp 3 0 0 0", la.size(), busy_o, host_ack_o, reg_wr_o);
    end
  endtask

`ifdef PTP_CFG_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    clear_log();
    init_rtc_i = 1;
    pulse_start();
    wait_n(5);
    ack_en = 0;
    wait_n(255);
    checks++;
    if (reg_wr_o !== 1 || reg_addr_o !== 8'h21) begin
      errors++; $display("FAIL timeout_hold got wr=%b addr=%h exp 1 21", reg_wr_o, reg_addr_o);
    end
    wait_n(1);
    checks++;
    if (reg_wr_o !== 0 || err_o !== 1 || done_o !== 0 || busy_o !== 0) begin
      errors++;
      $display("FAIL timeout_abort got wr=%b err=%b done=%b busy=%b exp 0 1 0 0", reg_wr_o, err_o, done_o, busy_o);
    end
    ack_en = 1;
    init_rtc_i = 0;
    wait_n(2);
  endtask
`endif

  task automatic test_rst_mid();
    clear_log();
    init_rtc_i = 1; ack_en = 0;
    pulse_start();
    wait_n(2);
    rst = 1;
    #1;
    checks++;
    if (reg_wr_o !== 0 || reg_rd_o !== 0 || busy_o !== 0 || done_o !== 0 || reg_addr_o !== 8'h0) begin
      errors++;
      $display("FAIL async_rst got wr=%b rd=%b busy=%b done=%b addr=%h exp 0 0 0 0 00", reg_wr_o, reg_rd_o, busy_o, done_o, reg_addr_o);
    end
    @(negedge clk);
    rst = 0; ack_en = 1;
    wait_n(1);
    clear_log();
    pulse_start();
    wait_n(18);
    checks++;
    if (done_o !== 1 || la.size() != 6) begin
      errors++; $display("FAIL rerun got done=%b writes=%0d exp 1 6", done_o, la.size());
    end else if (ld[5] !== 32'h1 || la[5] !== 8'h24 || ld[2] !== 32'h1234_5678) begin
      errors++; $display("FAIL rerun_data got last=%h:%h ns=%h exp 24:00000001 12345678", la[5], ld[5], ld[2]);
    end
  endtask

  initial begin
    test_reset();
    test_full_seq();
    test_short_seq();
    test_host_then_start();
    test_back_to_back();
`ifdef PTP_CFG_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
